// File: rtl/nrisc_loader_pkg.sv
// Shared encodings and constants for the nRisc host loader.
package nrisc_loader_pkg;

    localparam int unsigned LEN_W = 9;

    localparam logic [7:0] DONE_CODE_DEF    = 8'hA5;
    localparam logic [7:0] TIMEOUT_CODE_DEF = 8'hEE;

    typedef enum logic [1:0] {
        CMD_LOADI = 2'b00,
        CMD_LOADD = 2'b01,
        CMD_RUN   = 2'b10,
        CMD_DUMP  = 2'b11
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_ADDR  = 4'd1,
        ST_GET_LEN   = 4'd2,
        ST_WRITE     = 4'd3,
        ST_RUN       = 4'd4,
        ST_REPORT    = 4'd5,
        ST_DUMP_RD   = 4'd6,
        ST_DUMP_WAIT = 4'd7,
        ST_DUMP_SEND = 4'd8
    } state_e;

    // A length byte of zero stands for a full 256-byte block.
    function automatic logic [LEN_W-1:0] decode_len(input logic [7:0] b);
        return (b == 8'h00) ? LEN_W'(256) : LEN_W'(b);
    endfunction

endpackage

// File: rtl/nrisc_loader_outreg.sv
// Single-entry valid/ready holding register for status and dump bytes.
module nrisc_loader_outreg (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid
);

    // Data is frozen while valid; a new load is only taken once the slot is empty.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data  <= 8'h00;
            valid <= 1'b0;
        end else if (valid) begin
            if (ready) valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/nrisc_loader.sv
// Host byte-stream loader/monitor: loads memories, runs the core until HALT, dumps data memory.
module nrisc_loader
    import nrisc_loader_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned HALT_TIMEOUT = 1024,
    parameter logic [7:0]  DONE_CODE    = DONE_CODE_DEF,
    parameter logic [7:0]  TIMEOUT_CODE = TIMEOUT_CODE_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [7:0]        In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [7:0]        Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Inst_WE,
    output logic [ADDR_W-1:0] Inst_Addr,
    output logic [7:0]        Inst_WData,
    output logic              Data_WE,
    output logic              Data_RE,
    output logic [ADDR_W-1:0] Data_Addr,
    output logic [7:0]        Data_WData,
    input  logic [7:0]        Data_RData,
    output logic              Cpu_Reset,
    input  logic              Cpu_Halt,
    output logic              Busy,
    output logic              Err
);

    localparam int unsigned CNT_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT + 1) : 1;

    state_e            state_q;
    cmd_e              cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        wdata_q;
    logic [LEN_W-1:0]  len_q;
    logic [CNT_W-1:0]  cnt_q;

    logic       in_fire_c;
    logic       out_fire_c;
    logic       tmo_c;
    logic       load_c;
    logic [7:0] load_data_c;

    assign in_fire_c  = In_Valid & In_Ready;
    assign out_fire_c = Out_Valid & Out_Ready;
    assign tmo_c      = (HALT_TIMEOUT != 32'd0) && (cnt_q == CNT_W'(HALT_TIMEOUT));

    assign Inst_Addr  = mem_addr_q;
    assign Data_Addr  = mem_addr_q;
    assign Inst_WData = wdata_q;
    assign Data_WData = wdata_q;

    // Output slot is filled on the way into REPORT or DUMP_SEND.
    always_comb begin
        load_c      = 1'b0;
        load_data_c = Data_RData;
        if (state_q == ST_RUN && (Cpu_Halt || tmo_c)) begin
            load_c      = 1'b1;
            load_data_c = Cpu_Halt ? DONE_CODE : TIMEOUT_CODE;
        end else if (state_q == ST_DUMP_WAIT) begin
            load_c = 1'b1;
        end
    end

    nrisc_loader_outreg u_outreg (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (load_c),
        .load_data (load_data_c),
        .ready     (Out_Ready),
        .data      (Out_Data),
        .valid     (Out_Valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            cmd_q      <= CMD_LOADI;
            addr_q     <= '0;
            mem_addr_q <= '0;
            wdata_q    <= 8'h00;
            len_q      <= '0;
            cnt_q      <= '0;
            In_Ready   <= 1'b0;
            Cpu_Reset  <= 1'b1;
            Busy       <= 1'b0;
            Err        <= 1'b0;
            Inst_WE    <= 1'b0;
            Data_WE    <= 1'b0;
            Data_RE    <= 1'b0;
        end else begin
            Inst_WE <= 1'b0;
            Data_WE <= 1'b0;
            Data_RE <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    In_Ready <= 1'b1;
                    if (in_fire_c) begin
                        if (In_Data[5:0] != 6'd0) begin
                            Err <= 1'b1;
                        end else if (cmd_e'(In_Data[7:6]) == CMD_RUN) begin
                            state_q   <= ST_RUN;
                            Cpu_Reset <= 1'b0;
                            cnt_q     <= '0;
                            In_Ready  <= 1'b0;
                            Busy      <= 1'b1;
                        end else begin
                            cmd_q   <= cmd_e'(In_Data[7:6]);
                            state_q <= ST_GET_ADDR;
                            Busy    <= 1'b1;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (in_fire_c) begin
                        addr_q  <= ADDR_W'(In_Data);
                        state_q <= ST_GET_LEN;
                    end
                end
                ST_GET_LEN: begin
                    if (in_fire_c) begin
                        len_q <= decode_len(In_Data);
                        if (cmd_q == CMD_DUMP) begin
                            state_q    <= ST_DUMP_RD;
                            In_Ready   <= 1'b0;
                            Data_RE    <= 1'b1;
                            mem_addr_q <= addr_q;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end
                // Strobe for each accepted byte lands in the following cycle.
                ST_WRITE: begin
                    if (in_fire_c) begin
                        Inst_WE    <= (cmd_q == CMD_LOADI);
                        Data_WE    <= (cmd_q == CMD_LOADD);
                        mem_addr_q <= addr_q;
                        wdata_q    <= In_Data;
                        addr_q     <= addr_q + ADDR_W'(1);
                        len_q      <= len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) begin
                            state_q <= ST_IDLE;
                            Busy    <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (Cpu_Halt || tmo_c) begin
                        Cpu_Reset <= 1'b1;
                        state_q   <= ST_REPORT;
                        if (!Cpu_Halt) Err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (out_fire_c) begin
                        state_q  <= ST_IDLE;
                        In_Ready <= 1'b1;
                        Busy     <= 1'b0;
                    end
                end
                ST_DUMP_RD:   state_q <= ST_DUMP_WAIT;
                ST_DUMP_WAIT: state_q <= ST_DUMP_SEND;
                ST_DUMP_SEND: begin
                    if (out_fire_c) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        len_q  <= len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) begin
                            state_q  <= ST_IDLE;
                            In_Ready <= 1'b1;
                            Busy     <= 1'b0;
                        end else begin
                            state_q    <= ST_DUMP_RD;
                            Data_RE    <= 1'b1;
                            mem_addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    In_Ready  <= 1'b1;
                    Busy      <= 1'b0;
                    Cpu_Reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_loader.sv
// Self-checking bench for nrisc_loader: host link, memories and a toy core modelled here.
module tb_nrisc_loader;

    localparam int unsigned T_OUT = 64;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] In_Data = 8'h00;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] Out_Data;
    logic       Out_Valid;
    logic       Out_Ready = 1'b0;
    logic       Inst_WE;
    logic [7:0] Inst_Addr;
    logic [7:0] Inst_WData;
    logic       Data_WE;
    logic       Data_RE;
    logic [7:0] Data_Addr;
    logic [7:0] Data_WData;
    logic [7:0] Data_RData = 8'h00;
    logic       Cpu_Reset;
    logic       Cpu_Halt = 1'b0;
    logic       Busy;
    logic       Err;

    nrisc_loader #(.ADDR_W(8), .HALT_TIMEOUT(T_OUT)) dut (
        .CLK(CLK), .RESET(RESET),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Inst_WE(Inst_WE), .Inst_Addr(Inst_Addr), .Inst_WData(Inst_WData),
        .Data_WE(Data_WE), .Data_RE(Data_RE), .Data_Addr(Data_Addr),
        .Data_WData(Data_WData), .Data_RData(Data_RData),
        .Cpu_Reset(Cpu_Reset), .Cpu_Halt(Cpu_Halt), .Busy(Busy), .Err(Err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] mem_i [256];
    logic [7:0] mem_d [256];
    logic [7:0] ref_i [256];
    logic [7:0] ref_d [256];
    logic [15:0] wlog_i [$];
    logic [15:0] wlog_d [$];
    int wr_i_cnt = 0;
    int wr_d_cnt = 0;
    int cpu_low = 0;
    int viol = 0;
    bit pv = 0, pr = 0;
    logic [7:0] pd = 8'h00;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memories behind the loader's ports.
    always @(posedge CLK) begin
        if (Inst_WE) begin
            mem_i[Inst_Addr] = Inst_WData;
            wr_i_cnt++;
            wlog_i.push_back({Inst_Addr, Inst_WData});
        end
        if (Data_WE) begin
            mem_d[Data_Addr] = Data_WData;
            wr_d_cnt++;
            wlog_d.push_back({Data_Addr, Data_WData});
        end
        if (Data_RE) Data_RData <= mem_d[Data_Addr];
    end

    // Output hold rule, strobe ownership and run-cycle accounting.
    always @(negedge CLK) begin
        if (!RESET) begin
            pv = 0;
        end else begin
            if (pv && !pr) begin
                check("out_hold_valid", 32'(Out_Valid), 32'd1);
                check("out_hold_data", 32'(Out_Data), 32'(pd));
            end
            if (!Cpu_Reset) begin
                cpu_low++;
                if (Inst_WE || Data_WE || Data_RE) viol++;
            end
            pv = Out_Valid;
            pr = Out_Ready;
            pd = Out_Data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit r;
        int t;
        In_Valid = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
        In_Data = b;
        In_Valid = 1'b1;
        r = 0;
        t = 0;
        while (!r && t < 100) begin
            @(negedge CLK);
            r = In_Ready;
            @(posedge CLK);
            #1;
            t++;
        end
        In_Valid = 1'b0;
        check("in_accept", 32'(r), 32'd1);
    endtask

    // mode 0: always ready, 1: toggle each cycle, 2: random
    task automatic recv_byte(input int mode, output logic [7:0] d, output bit ok);
        bit v, rd;
        int t;
        ok = 0;
        t = 0;
        d = 8'h00;
        while (!ok && t < 200) begin
            case (mode)
                0: Out_Ready = 1'b1;
                1: Out_Ready = ~Out_Ready;
                default: Out_Ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge CLK);
            v = Out_Valid;
            rd = Out_Ready;
            d = Out_Data;
            @(posedge CLK);
            #1;
            t++;
            if (v && rd) ok = 1;
        end
        Out_Ready = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (Busy && t < 100) begin @(posedge CLK); #1; t++; end
        @(posedge CLK); #1;
        check(nm, 32'(Busy), 32'd0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b0;
        Cpu_Halt = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
    endtask

    task automatic load_block(input logic [7:0] cmd, input logic [7:0] a, input int n,
                              input bit rnd_gap);
        logic [7:0] b;
        send_byte(cmd, 0);
        send_byte(a, 0);
        send_byte(8'(n), 0);
        for (int i = 0; i < ((n == 0) ? 256 : n); i++) begin
            b = 8'($urandom);
            send_byte(b, rnd_gap ? int'($urandom_range(0, 2)) : 0);
            if (cmd == 8'h00) ref_i[8'(a + i)] = b;
            else              ref_d[8'(a + i)] = b;
        end
    endtask

    task automatic dump_check(input logic [7:0] a, input int n, input int mode, input string nm);
        logic [7:0] d;
        bit ok;
        send_byte(8'hC0, 0);
        send_byte(a, 0);
        send_byte(8'(n), 0);
        for (int i = 0; i < ((n == 0) ? 256 : n); i++) begin
            recv_byte(mode, d, ok);
            check({nm, "_hs"}, 32'(ok), 32'd1);
            check(nm, 32'(d), 32'(ref_d[8'(a + i)]));
        end
        wait_idle({nm, "_idle"});
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    initial begin
        logic [7:0] prog [11];
        logic [7:0] dvals [5];
        logic [7:0] dexp [5];
        logic [7:0] wexp [3];
        logic [7:0] d;
        bit ok;
        vec_t tbl [6];
        int c0, w0, t, mism;
        logic [7:0] a;
        int n, op;

        prog = '{8'h88, 8'h91, 8'h9D, 8'h42, 8'hA1, 8'h24, 8'h43, 8'h2C, 8'hAE, 8'hE3, 8'h00};
        dvals = '{8'h05, 8'h08, 8'hFF, 8'h01, 8'h0A};
        dexp = '{8'hFB, 8'hF8, 8'h01, 8'hFF, 8'hF6};
        wexp = '{8'h11, 8'h22, 8'h33};
        tbl[0] = '{8'h81, 1'b1, 1'b0};
        tbl[1] = '{8'h01, 1'b1, 1'b0};
        tbl[2] = '{8'h3F, 1'b1, 1'b0};
        tbl[3] = '{8'hC1, 1'b1, 1'b0};
        tbl[4] = '{8'h7F, 1'b1, 1'b0};
        tbl[5] = '{8'hA0, 1'b1, 1'b0};
        for (int i = 0; i < 256; i++) begin
            mem_i[i] = 8'h00; mem_d[i] = 8'h00; ref_i[i] = 8'h00; ref_d[i] = 8'h00;
        end

        // Reset values
        repeat (2) begin @(posedge CLK); #1; end
        check("rst_cpu_reset", 32'(Cpu_Reset), 32'd1);
        check("rst_in_ready", 32'(In_Ready), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_out_valid", 32'(Out_Valid), 32'd0);
        check("rst_out_data", 32'(Out_Data), 32'd0);
        check("rst_strobes", 32'({Inst_WE, Data_WE, Data_RE}), 32'd0);
        RESET = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        check("idle_in_ready", 32'(In_Ready), 32'd1);

        // LOADI of the program
        c0 = cpu_low;
        wlog_i.delete();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h0B, 0);
        foreach (prog[i]) begin
            send_byte(prog[i], i % 3);
            ref_i[8'(i)] = prog[i];
        end
        wait_idle("t1_idle");
        check("t1_wcount", 32'(wlog_i.size()), 32'd11);
        for (int i = 0; i < 11 && i < wlog_i.size(); i++) begin
            check("t1_waddr", 32'(wlog_i[i][15:8]), 32'(i));
            check("t1_wdata", 32'(wlog_i[i][7:0]), 32'(prog[i]));
        end
        check("t1_cpu_held", 32'(cpu_low - c0), 32'd0);

        // LOADD, then RUN with a core that negates data[0..4] and halts after 60 cycles
        send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        foreach (dvals[i]) begin
            send_byte(dvals[i], 0);
            ref_d[8'(i)] = dvals[i];
        end
        wait_idle("t2_load_idle");
        c0 = cpu_low;
        send_byte(8'h80, 0);
        check("t2_cpu_fall", 32'(Cpu_Reset), 32'd0);
        check("t2_in_ready_run", 32'(In_Ready), 32'd0);
        repeat (30) begin @(posedge CLK); #1; end
        for (int i = 0; i < 5; i++) begin
            mem_d[i] = 8'(8'h00 - mem_d[i]);
            ref_d[8'(i)] = 8'(8'h00 - ref_d[8'(i)]);
        end
        repeat (30) begin @(posedge CLK); #1; end
        Cpu_Halt = 1'b1;
        @(posedge CLK); #1;
        Cpu_Halt = 1'b0;
        check("t2_cpu_rise", 32'(Cpu_Reset), 32'd1);
        check("t2_run_cycles", 32'(cpu_low - c0), 32'd61);
        check("t2_out_valid", 32'(Out_Valid), 32'd1);
        check("t2_out_done", 32'(Out_Data), 32'hA5);
        repeat (4) begin @(posedge CLK); #1; end
        recv_byte(0, d, ok);
        check("t2_done_hs", 32'(ok), 32'd1);
        check("t2_done_code", 32'(d), 32'hA5);
        wait_idle("t2_idle");
        check("t2_err", 32'(Err), 32'd0);

        // DUMP of the negated words with toggling Out_Ready
        w0 = wr_d_cnt;
        send_byte(8'hC0, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
        for (int i = 0; i < 5; i++) begin
            recv_byte(1, d, ok);
            check("t3_dump_hs", 32'(ok), 32'd1);
            check("t3_dump", 32'(d), 32'(dexp[i]));
        end
        wait_idle("t3_idle");
        check("t3_no_data_we", 32'(wr_d_cnt - w0), 32'd0);

        // Address wrap and 256-byte block
        wlog_d.delete();
        send_byte(8'h40, 0); send_byte(8'hFE, 0); send_byte(8'h03, 0);
        foreach (wexp[i]) begin
            send_byte(wexp[i], 1);
            ref_d[8'(8'hFE + i)] = wexp[i];
        end
        wait_idle("t4_idle");
        check("t4_wcount", 32'(wlog_d.size()), 32'd3);
        for (int i = 0; i < 3 && i < wlog_d.size(); i++) begin
            check("t4_waddr", 32'(wlog_d[i][15:8]), 32'(8'(8'hFE + i)));
            check("t4_wdata", 32'(wlog_d[i][7:0]), 32'(wexp[i]));
        end
        w0 = wr_d_cnt;
        load_block(8'h40, 8'h10, 0, 1'b0);
        wait_idle("t4_full_idle");
        check("t4_full_count", 32'(wr_d_cnt - w0), 32'd256);
        dump_check(8'h10, 0, 2, "t4_full_dump");

        // Malformed command bytes, then a good command
        check("t5_err_clear", 32'(Err), 32'd0);
        foreach (tbl[i]) begin
            send_byte(tbl[i].cmd, 0);
            @(posedge CLK); #1;
            check("t5_bad_err", 32'(Err), 32'(tbl[i].exp_err));
            check("t5_bad_busy", 32'(Busy), 32'(tbl[i].exp_busy));
            check("t5_bad_ready", 32'(In_Ready), 32'd1);
        end
        send_byte(8'h40, 0); send_byte(8'h20, 0); send_byte(8'h01, 0); send_byte(8'h77, 0);
        ref_d[8'h20] = 8'h77;
        wait_idle("t5_good_idle");
        check("t5_good_write", 32'(mem_d[8'h20]), 32'h77);

        // RUN timeout with no HALT
        do_reset();
        check("t5_err_after_reset", 32'(Err), 32'd0);
        c0 = cpu_low;
        send_byte(8'h80, 0);
        t = 0;
        while (!Cpu_Reset && t < 300) begin @(posedge CLK); #1; t++; end
        check("t5_tmo_cpu_rise", 32'(Cpu_Reset), 32'd1);
        check("t5_tmo_cycles", 32'((cpu_low - c0 == T_OUT) || (cpu_low - c0 == T_OUT + 1)), 32'd1);
        check("t5_tmo_valid", 32'(Out_Valid), 32'd1);
        check("t5_tmo_code", 32'(Out_Data), 32'hEE);
        check("t5_tmo_err", 32'(Err), 32'd1);
        recv_byte(2, d, ok);
        check("t5_tmo_hs", 32'(ok && d == 8'hEE), 32'd1);
        wait_idle("t5_tmo_idle");

        // Reset in the middle of a LOADI
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h40, 0); send_byte(8'h05, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        #3;
        RESET = 1'b0;
        #1;
        check("t6_cpu_reset", 32'(Cpu_Reset), 32'd1);
        check("t6_in_ready", 32'(In_Ready), 32'd0);
        check("t6_busy", 32'(Busy), 32'd0);
        check("t6_inst_we", 32'(Inst_WE), 32'd0);
        w0 = wr_i_cnt;
        repeat (3) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        check("t6_no_more_writes", 32'(wr_i_cnt - w0), 32'd0);
        ref_i[8'h40] = 8'hAA;
        check("t6_first_byte", 32'(mem_i[8'h40]), 32'hAA);
        check("t6_killed_byte", 32'(mem_i[8'h41]), 32'(ref_i[8'h41]));
        send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h01, 0); send_byte(8'hAB, 0);
        ref_i[8'h50] = 8'hAB;
        wait_idle("t6_idle");
        check("t6_new_cmd", 32'(mem_i[8'h50]), 32'hAB);

        // Randomized loads and dumps against the memory image model
        for (int k = 0; k < 30; k++) begin
            op = int'($urandom_range(0, 2));
            a = 8'($urandom);
            n = int'($urandom_range(1, 12));
            if (op == 2) dump_check(a, n, 2, "rnd_dump");
            else begin
                load_block((op == 0) ? 8'h00 : 8'h40, a, n, 1'b1);
                wait_idle("rnd_load_idle");
            end
        end
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem_i[i] !== ref_i[i]) mism++;
            if (mem_d[i] !== ref_d[i]) mism++;
        end
        check("mem_image", 32'(mism), 32'd0);
        check("no_strobe_while_running", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
